// File: rtl/v2f_limb_alu_pkg.sv
// Shared types and constants for the limb-serial wide add/sub/compare unit.
package v2f_pkg;

    localparam int V2F_LIMB = 31;

    typedef enum logic [1:0] {
        V2F_OP_ADD = 2'd0,
        V2F_OP_SUB = 2'd1,
        V2F_OP_EQ  = 2'd2,
        V2F_OP_LT  = 2'd3
    } v2f_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } v2f_state_e;

    function automatic int v2f_cdiv(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/v2f_limb_slice.sv
// Combinational single-limb adder. For the top limb only the low TOP_W bits
// take part, and the carry is taken at bit TOP_W.
module v2f_limb_slice #(
    parameter int W     = 31,
    parameter int TOP_W = 31
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         inv_b,
    input  logic         cin,
    input  logic         is_top,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         eq
);

    localparam logic [W-1:0] TOP_MASK = {W{1'b1}} >> (W - TOP_W);

    logic [W-1:0] mask;
    logic [W-1:0] a_m;
    logic [W-1:0] b_m;
    logic [W:0]   s;

    always_comb begin
        mask = is_top ? TOP_MASK : {W{1'b1}};
        a_m  = a & mask;
        b_m  = (inv_b ? ~b : b) & mask;
        s    = {1'b0, a_m} + {1'b0, b_m} + {{W{1'b0}}, cin};
        sum  = s[W-1:0];
        cout = is_top ? s[TOP_W] : s[W];
        eq   = (a_m == (b & mask));
    end

endmodule

// File: rtl/v2f_limb_alu.sv
// Limb-serial add/sub/eq/lt for operands wider than one combinator signal.
// Optional saturation of ADD/SUB is built when V2F_LIMB_ALU_SAT_EN is defined.
module v2f_limb_alu
    import v2f_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int SIGNED = 0,
    parameter int LIMB   = V2F_LIMB,
    parameter int NLIMB  = v2f_cdiv(WIDTH, LIMB)
) (
    input  logic             CLK,
    input  logic             ARST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             FLAG
);

    localparam int XW   = NLIMB * LIMB;
    localparam int TOPW = WIDTH - (NLIMB - 1) * LIMB;
    localparam int CW   = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    v2f_state_e       state;
    v2f_op_e          op_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             eq_acc;
    logic [XW-1:0]    a_q;
    logic [XW-1:0]    b_q;
    logic [XW-1:0]    acc;
    logic [XW-1:0]    res_w;
    logic [LIMB-1:0]  sum_l;
    logic             cout_l;
    logic             eq_l;
    logic             is_top;
    logic             inv_b;
    logic [WIDTH-1:0] fin_y;
    logic             fin_f;
    logic             fin_lt;

`ifdef V2F_LIMB_ALU_SAT_EN
    // Returns {clamped, value}; when nothing clamps, the flag is carry/borrow.
    function automatic logic [WIDTH:0] sat_fn(input v2f_op_e op, input logic [WIDTH-1:0] r,
                                              input logic c, input logic am, input logic bm);
        logic             ovf;
        logic [WIDTH-1:0] maxv;
        maxv = {WIDTH{1'b1}} >> 1;
        if (SIGNED != 0) begin
            ovf = (op == V2F_OP_ADD) ? (am == bm && r[WIDTH-1] != am)
                                     : (am != bm && r[WIDTH-1] != am);
            if (ovf) return {1'b1, am ? ~maxv : maxv};
        end else begin
            if (op == V2F_OP_ADD && c)  return {1'b1, {WIDTH{1'b1}}};
            if (op == V2F_OP_SUB && !c) return {1'b1, {WIDTH{1'b0}}};
        end
        return {(op == V2F_OP_ADD) ? c : ~c, r};
    endfunction
`endif

    assign is_top = (int'(cnt) == NLIMB - 1);
    assign inv_b  = (op_q == V2F_OP_SUB) || (op_q == V2F_OP_LT);

    v2f_limb_slice #(.W(LIMB), .TOP_W(TOPW)) u_slice (
        .a      (a_q[int'(cnt)*LIMB +: LIMB]),
        .b      (b_q[int'(cnt)*LIMB +: LIMB]),
        .inv_b  (inv_b),
        .cin    (carry),
        .is_top (is_top),
        .sum    (sum_l),
        .cout   (cout_l),
        .eq     (eq_l)
    );

    // Result as it stands once the current limb is merged in; only the
    // top-limb cycle uses the finalised value.
    always_comb begin
        res_w = acc;
        res_w[int'(cnt)*LIMB +: LIMB] = sum_l;
        fin_lt = (SIGNED != 0 && a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : ~cout_l;
        fin_y  = res_w[WIDTH-1:0];
        fin_f  = cout_l;
        case (op_q)
            V2F_OP_ADD: fin_f = cout_l;
            V2F_OP_SUB: fin_f = ~cout_l;
            V2F_OP_EQ: begin
                fin_y = WIDTH'(eq_acc & eq_l);
                fin_f = eq_acc & eq_l;
            end
            default: begin
                fin_y = WIDTH'(fin_lt);
                fin_f = fin_lt;
            end
        endcase
`ifdef V2F_LIMB_ALU_SAT_EN
        if (op_q == V2F_OP_ADD || op_q == V2F_OP_SUB)
            {fin_f, fin_y} = sat_fn(op_q, res_w[WIDTH-1:0], cout_l, a_q[WIDTH-1], b_q[WIDTH-1]);
`endif
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state     <= ST_IDLE;
            op_q      <= V2F_OP_ADD;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            Y         <= '0;
            FLAG      <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            eq_acc    <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        a_q      <= XW'(A);
                        b_q      <= XW'(B);
                        op_q     <= v2f_op_e'(OP);
                        carry    <= (OP == V2F_OP_SUB) || (OP == V2F_OP_LT);
                        eq_acc   <= 1'b1;
                        cnt      <= '0;
                        IN_READY <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc    <= res_w;
                    carry  <= cout_l;
                    eq_acc <= eq_acc & eq_l;
                    if (is_top) begin
                        Y         <= fin_y;
                        FLAG      <= fin_f;
                        OUT_VALID <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
